// File: rtl/rgb_sort_sched.sv
// rgb_sort_sched
//
// Scheduler and result filter for the 16-tile RGB colour sorter in the
// klotski camera path. When the block averager finishes a frame, the 16
// block colours are snapshotted and one sort is launched. The FSM waits for
// the sorter, bounded by a timeout, and then checks the returned 64-bit
// tile-label order. A label order reaches the solver/display only after it
// has been seen on STABLE_CNT consecutive valid results, which hides flicker
// caused by camera noise.
//
// Parameters:
//   STABLE_CNT  consecutive identical valid orders needed to publish (1..15)
//   TIMEOUT     cycles allowed in S_WAIT for i_sort_done (2..255)
//
// Ports:
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_enable         level; 0 refuses new frames (an in-flight sort finishes)
//   i_clear          pulse; clears o_order_valid, o_timeout, match state, o_drop_cnt
//   i_frame_done     pulse; i_blocks valid this cycle
//   i_blocks         16 x 24-bit {R,G,B}, block k at [24k+23:24k]
//   o_sort_start     one-cycle start pulse to the sorter
//   o_sort_blocks    registered colour snapshot feeding the sorter
//   i_sort_done      sorter completion pulse
//   i_sort_order     sorter result, label of tile k at [63-4k -: 4]
//   o_order          published order
//   o_order_valid    o_order holds a stable result
//   o_update         one-cycle pulse when o_order is (re)published
//   o_busy           FSM is not idle
//   o_timeout        sticky timeout flag
//   o_drop_cnt       saturating count of frames dropped while busy/disabled
//
// Build option:
//   RGB_SORT_SCHED_PERM_CHECK_EN  when defined, an order is valid only if its
//                                 16 labels are a permutation of 0..15;
//                                 otherwise every returned order is valid.

module rgb_sort_sched #(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  input  logic         i_clear,
  input  logic         i_frame_done,
  input  logic [383:0] i_blocks,
  output logic         o_sort_start,
  output logic [383:0] o_sort_blocks,
  input  logic         i_sort_done,
  input  logic [63:0]  i_sort_order,
  output logic [63:0]  o_order,
  output logic         o_order_valid,
  output logic         o_update,
  output logic         o_busy,
  output logic         o_timeout,
  output logic [7:0]   o_drop_cnt
);

  localparam logic [3:0] STABLE_W   = 4'(STABLE_CNT);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t         state_q;
  logic [7:0]     wait_cnt_q;
  logic [63:0]    new_q;
  logic [63:0]    last_q;
  logic [63:0]    last_d;
  logic [3:0]     match_cnt_q;
  logic [3:0]     match_cnt_d;
  logic [383:0]   sort_blocks_q;
  logic           sort_start_q;
  logic [63:0]    order_q;
  logic           order_valid_q;
  logic           update_q;
  logic           timeout_q;
  logic [7:0]     drop_cnt_q;
  logic           order_ok;
  logic           publish;
  logic           drop_event;

`ifdef RGB_SORT_SCHED_PERM_CHECK_EN
  // One-hot OR of all 16 labels: all 16 bits set only when every value
  // 0..15 appears, which with 16 labels means each appears exactly once.
  logic [15:0] label_seen;

  always_comb begin
    label_seen = '0;
    for (int k = 0; k < 16; k++) begin
      label_seen = label_seen | (16'h0001 << new_q[63-4*k -: 4]);
    end
  end

  assign order_ok = &label_seen;
`else
  assign order_ok = 1'b1;
`endif

  // Match-state update for the result sitting in new_q; only committed in
  // S_CHECK. The publish decision uses the updated state so a run reaching
  // STABLE_CNT publishes on the same check.
  always_comb begin
    last_d      = last_q;
    match_cnt_d = match_cnt_q;
    if (!order_ok) begin
      last_d      = '0;
      match_cnt_d = '0;
    end else if (new_q == last_q) begin
      if (match_cnt_q != STABLE_W) begin
        match_cnt_d = match_cnt_q + 4'd1;
      end
    end else begin
      last_d      = new_q;
      match_cnt_d = 4'd1;
    end
    publish = (match_cnt_d == STABLE_W) && (!order_valid_q || (last_d != order_q));
  end

  // A frame is dropped whenever it cannot be accepted: FSM busy or disabled.
  assign drop_event = i_frame_done && ((state_q != S_IDLE) || !i_enable);

  // Main FSM and all registered outputs. i_clear is applied last so it wins
  // over a publish or a drop-count increment in the same cycle; it leaves the
  // FSM itself alone so an in-flight sort still completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      new_q         <= '0;
      last_q        <= '0;
      match_cnt_q   <= '0;
      sort_blocks_q <= '0;
      sort_start_q  <= 1'b0;
      order_q       <= '0;
      order_valid_q <= 1'b0;
      update_q      <= 1'b0;
      timeout_q     <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      sort_start_q <= 1'b0;
      update_q     <= 1'b0;

      if (drop_event && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (i_frame_done && i_enable) begin
            sort_blocks_q <= i_blocks;
            sort_start_q  <= 1'b1;
            state_q       <= S_START;
          end
        end

        S_START: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (i_sort_done) begin
            new_q   <= i_sort_order;
            state_q <= S_CHECK;
          end else if ((wait_cnt_q + 8'd1) == WAIT_LIMIT) begin
            // Leaves S_WAIT exactly TIMEOUT cycles after S_START.
            timeout_q   <= 1'b1;
            last_q      <= '0;
            match_cnt_q <= '0;
            state_q     <= S_IDLE;
          end
        end

        S_CHECK: begin
          last_q      <= last_d;
          match_cnt_q <= match_cnt_d;
          if (publish && !i_clear) begin
            order_q       <= last_d;
            order_valid_q <= 1'b1;
            update_q      <= 1'b1;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      if (i_clear) begin
        order_valid_q <= 1'b0;
        timeout_q     <= 1'b0;
        last_q        <= '0;
        match_cnt_q   <= '0;
        drop_cnt_q    <= '0;
        update_q      <= 1'b0;
      end
    end
  end

  assign o_sort_start  = sort_start_q;
  assign o_sort_blocks = sort_blocks_q;
  assign o_order       = order_q;
  assign o_order_valid = order_valid_q;
  assign o_update      = update_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout     = timeout_q;
  assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rgb_sort_sched.sv
// tb_rgb_sort_sched
//
// Self-checking bench for rgb_sort_sched (STABLE_CNT=3, TIMEOUT=64). The
// bench plays the sorter itself, keeps a reference model of the match and
// publish behaviour, and pushes every order it expects to be published onto
// a scoreboard queue that is popped when o_update fires. Expectations for
// the permutation check follow RGB_SORT_SCHED_PERM_CHECK_EN.

module tb_rgb_sort_sched;

  localparam int STABLE  = 3;
  localparam int TIMEOUT = 64;

`ifdef RGB_SORT_SCHED_PERM_CHECK_EN
  localparam bit PERM_CHECK = 1'b1;
`else
  localparam bit PERM_CHECK = 1'b0;
`endif

  localparam logic [63:0] ORDER_X   = 64'h0123456789ABCDEF;
  localparam logic [63:0] ORDER_A   = 64'h1032547698BADCFE;
  localparam logic [63:0] ORDER_B   = 64'hFEDCBA9876543210;
  localparam logic [63:0] ORDER_DUP = 64'h0023456789ABCDEF;

  logic         clk;
  logic         rstN;
  logic         enable;
  logic         clear;
  logic         frameDone;
  logic [383:0] blocks;
  logic         sortDone;
  logic [63:0]  sortOrder;

  logic         sortStart;
  logic [383:0] sortBlocks;
  logic [63:0]  order;
  logic         orderValid;
  logic         update;
  logic         busy;
  logic         timeoutFlag;
  logic [7:0]   dropCnt;

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;

  // Reference model of the match / publish state.
  logic [63:0] mLast;
  int          mCnt;
  logic        mValid;
  logic [63:0] mOrder;
  logic [63:0] expQ[$];

  rgb_sort_sched #(
    .STABLE_CNT(STABLE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_enable     (enable),
    .i_clear      (clear),
    .i_frame_done (frameDone),
    .i_blocks     (blocks),
    .o_sort_start (sortStart),
    .o_sort_blocks(sortBlocks),
    .i_sort_done  (sortDone),
    .i_sort_order (sortOrder),
    .o_order      (order),
    .o_order_valid(orderValid),
    .o_update     (update),
    .o_busy       (busy),
    .o_timeout    (timeoutFlag),
    .o_drop_cnt   (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isPermutation(input logic [63:0] ord);
    int seen [16];
    for (int v = 0; v < 16; v++) seen[v] = 0;
    for (int k = 0; k < 16; k++) seen[ord[63-4*k -: 4]]++;
    for (int v = 0; v < 16; v++) begin
      if (seen[v] != 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    mLast  = '0;
    mCnt   = 0;
    mValid = 1'b0;
    mOrder = '0;
  endtask

  // Apply one sorter result to the model; pushes the expected publish.
  task automatic modelResult(input logic [63:0] ord, input bit clearAtCheck, output bit pub);
    pub = 1'b0;
    if (clearAtCheck) begin
      mLast  = '0;
      mCnt   = 0;
      mValid = 1'b0;
    end else begin
      if (PERM_CHECK && !isPermutation(ord)) begin
        mLast = '0;
        mCnt  = 0;
      end else if (ord == mLast) begin
        if (mCnt < STABLE) mCnt++;
      end else begin
        mLast = ord;
        mCnt  = 1;
      end
      pub = (mCnt == STABLE) && (!mValid || (mLast != mOrder));
      if (pub) begin
        mOrder = mLast;
        mValid = 1'b1;
        expQ.push_back(mLast);
      end
    end
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, "_sort_start"},  384'(sortStart),   384'(0));
    checkOutput({where, "_busy"},        384'(busy),        384'(0));
    checkOutput({where, "_order"},       384'(order),       384'(0));
    checkOutput({where, "_order_valid"}, 384'(orderValid),  384'(0));
    checkOutput({where, "_update"},      384'(update),      384'(0));
    checkOutput({where, "_timeout"},     384'(timeoutFlag), 384'(0));
    checkOutput({where, "_drop_cnt"},    384'(dropCnt),     384'(0));
    checkOutput({where, "_sort_blocks"}, sortBlocks,        384'(0));
  endtask

  // Present a frame; returns with the DUT in S_WAIT.
  task automatic applyStimulus(input logic [383:0] blk);
    blocks    = blk;
    frameDone = 1'b1;
    step();
    frameDone = 1'b0;
    blocks    = {12{$urandom()}};
    checkOutput("sort_start",  384'(sortStart), 384'(1));
    checkOutput("sort_blocks", sortBlocks,      blk);
    checkOutput("busy_start",  384'(busy),      384'(1));
    step();
    checkOutput("sort_start_width", 384'(sortStart), 384'(0));
  endtask

  // Answer as the sorter after 'latency' further cycles and check the result.
  task automatic finishSort(input logic [63:0] ord, input int latency, input bit clearAtCheck);
    bit pub;
    logic [63:0] expOrder;
    repeat (latency) step();
    sortDone  = 1'b1;
    sortOrder = ord;
    step();
    sortDone  = 1'b0;
    sortOrder = {$urandom(), $urandom()};
    checkOutput("update_in_check", 384'(update), 384'(0));
    checkOutput("busy_in_check",   384'(busy),   384'(1));
    clear = clearAtCheck;
    step();
    clear = 1'b0;
    modelResult(ord, clearAtCheck, pub);
    checkOutput("update",    384'(update), 384'(pub));
    checkOutput("busy_done", 384'(busy),   384'(0));
    if (pub) begin
      expOrder = expQ.pop_front();
      checkOutput("order", 384'(order), 384'(expOrder));
    end
    checkOutput("order_valid", 384'(orderValid), 384'(mValid));
    step();
    checkOutput("update_width", 384'(update), 384'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [383:0] snap;

    rstN      = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    frameDone = 1'b0;
    blocks    = '0;
    sortDone  = 1'b0;
    sortOrder = '0;
    modelReset();

    $display("[TB] reset values");
    step();
    step();
    checkAllZero("reset");
    rstN = 1'b1;
    step();

    $display("[TB] three identical orders publish once, fourth does not");
    for (int i = 0; i < 4; i++) begin
      applyStimulus({12{$urandom()}});
      finishSort(ORDER_X, 3, 1'b0);
    end
    checkOutput("stable_order",       384'(order),      384'(ORDER_X));
    checkOutput("stable_order_valid", 384'(orderValid), 384'(1));

    $display("[TB] A,A,B,B,B publishes only B");
    for (int i = 0; i < 5; i++) begin
      applyStimulus({12{$urandom()}});
      finishSort((i < 2) ? ORDER_A : ORDER_B, 2 + i, 1'b0);
    end
    checkOutput("ab_order", 384'(order), 384'(ORDER_B));

    $display("[TB] duplicate-label order three times");
    for (int i = 0; i < 3; i++) begin
      applyStimulus({12{$urandom()}});
      finishSort(ORDER_DUP, 1, 1'b0);
    end
    checkOutput("dup_order", 384'(order), 384'(PERM_CHECK ? ORDER_B : ORDER_DUP));

    $display("[TB] clear in the check cycle discards the publish");
    for (int i = 0; i < 3; i++) begin
      applyStimulus({12{$urandom()}});
      finishSort(ORDER_X, 0, (i == 2));
    end
    checkOutput("clear_valid", 384'(orderValid), 384'(0));
    applyStimulus({12{$urandom()}});
    finishSort(ORDER_X, 0, 1'b0);

    $display("[TB] sorter never answers");
    applyStimulus({12{$urandom()}});
    repeat (TIMEOUT - 2) step();
    checkOutput("timeout_early", 384'(timeoutFlag), 384'(0));
    checkOutput("busy_early",    384'(busy),        384'(1));
    step();
    checkOutput("timeout_exact", 384'(timeoutFlag), 384'(1));
    checkOutput("busy_timeout",  384'(busy),        384'(0));
    mLast = '0;
    mCnt  = 0;
    sortDone  = 1'b1;
    sortOrder = ORDER_B;
    step();
    sortDone = 1'b0;
    step();
    step();
    checkOutput("late_update",  384'(update),      384'(0));
    checkOutput("late_busy",    384'(busy),        384'(0));
    checkOutput("late_order",   384'(order),       384'(mOrder));
    checkOutput("late_sticky",  384'(timeoutFlag), 384'(1));
    applyStimulus({12{$urandom()}});
    finishSort(ORDER_A, 4, 1'b0);

    $display("[TB] dropped frames and clear");
    snap = {12{$urandom()}};
    applyStimulus(snap);
    for (int i = 0; i < 5; i++) begin
      blocks    = {12{$urandom()}};
      frameDone = 1'b1;
      step();
      frameDone = 1'b0;
      step();
    end
    checkOutput("drop_busy",        384'(dropCnt), 384'(5));
    checkOutput("drop_busy_blocks", sortBlocks,    snap);
    finishSort(ORDER_A, 0, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blocks    = {12{$urandom()}};
      frameDone = 1'b1;
      step();
      frameDone = 1'b0;
      step();
      checkOutput("drop_disabled_busy", 384'(busy), 384'(0));
    end
    checkOutput("drop_total",  384'(dropCnt), 384'(8));
    checkOutput("drop_blocks", sortBlocks,    snap);
    clear = 1'b1;
    step();
    clear = 1'b0;
    mLast  = '0;
    mCnt   = 0;
    mValid = 1'b0;
    checkOutput("clear_drop",    384'(dropCnt),     384'(0));
    checkOutput("clear_valid2",  384'(orderValid),  384'(0));
    checkOutput("clear_timeout", 384'(timeoutFlag), 384'(0));
    frameDone = 1'b1;
    clear     = 1'b1;
    step();
    frameDone = 1'b0;
    clear     = 1'b0;
    checkOutput("clear_beats_drop", 384'(dropCnt), 384'(0));
    enable = 1'b1;

    $display("[TB] reset during S_WAIT");
    applyStimulus({12{$urandom()}});
    step();
    rstN = 1'b0;
    #1;
    checkAllZero("midreset");
    step();
    rstN = 1'b1;
    modelReset();
    step();
    checkAllZero("released");
    sortDone  = 1'b1;
    sortOrder = ORDER_X;
    step();
    sortDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stale_update", 384'(update),    384'(0));
      checkOutput("stale_start",  384'(sortStart), 384'(0));
      checkOutput("stale_busy",   384'(busy),      384'(0));
    end

    checkOutput("queue_drained", 384'(expQ.size()), 384'(0));
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/rgb_sort_sched.md
# rgb_sort_sched

Scheduler and result filter for the 16-tile RGB colour sorter in the klotski camera path. It snapshots the 16 block-average colours when the averager finishes a frame, and launches one sort per accepted frame. It waits for completion with a timeout and validates the returned 64-bit tile-label order. A label order is published to the solver/display only after it has repeated on enough consecutive frames, which suppresses flicker from camera noise.

## Interface
Parameters:
- STABLE_CNT, 3: consecutive identical valid orders required before publish; legal range 1..15.
- TIMEOUT, 64: cycles allowed in S_WAIT for i_sort_done; legal range 2..255.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  level; 0 blocks acceptance of new frames; an in-flight sort still completes.
- i_clear  in  1  sync pulse; clears o_order_valid, o_timeout, the match state and o_drop_cnt.
- i_frame_done  in  1  pulse; i_blocks is valid in this cycle.
- i_blocks  in  384  16×24-bit {R,G,B} colours; block k is at [24k+23:24k].
- o_sort_start  out  1  one-cycle start pulse to the sorter.
- o_sort_blocks  out  384  registered snapshot driven to the sorter inputs; stable from S_START until the next accept.
- i_sort_done  in  1  sorter completion pulse.
- i_sort_order  in  64  sorter result; label of tile k is at [63-4k -: 4]. Sampled only with i_sort_done.
- o_order  out  64  published order.
- o_order_valid  out  1  o_order holds a stable result.
- o_update  out  1  one-cycle pulse when o_order changes.
- o_busy  out  1  high whenever the FSM is not in S_IDLE.
- o_timeout  out  1  sticky timeout flag.
- o_drop_cnt  out  8  saturating count of frames dropped while busy or disabled.

## Operation
FSM states: S_IDLE, S_START, S_WAIT, S_CHECK.
- S_IDLE:
  - If i_frame_done and i_enable: latch i_blocks into o_sort_blocks and go to S_START.
  - If i_frame_done and !i_enable: increment o_drop_cnt.
- S_START: drive o_sort_start=1 for exactly this cycle, clear the wait counter, go to S_WAIT.
- S_WAIT: increment the wait counter each cycle.
  - On i_sort_done: capture i_sort_order into new_r and go to S_CHECK.
  - Otherwise, when the counter reaches TIMEOUT-1: set o_timeout, reset the match state, go to S_IDLE.
- S_CHECK: run the validity check (see Configuration), update the match state, then go to S_IDLE.
  - Invalid order: match state reset; last_r and match_cnt cleared to 0.
  - Valid and new_r==last_r: match_cnt+1, saturating at STABLE_CNT.
  - Valid and new_r!=last_r: last_r=new_r, match_cnt=1.
  - Publish when the updated match_cnt==STABLE_CNT and (!o_order_valid or last_r!=o_order):
    - o_order=last_r
    - o_order_valid=1
    - o_update=1 for one cycle
- Dropped frames: any i_frame_done seen outside S_IDLE increments o_drop_cnt, saturating at 255. Such a frame never touches o_sort_blocks.
- i_sort_done outside S_WAIT is ignored.
- i_clear:
  - Takes priority over the S_CHECK publish in the same cycle; the result is discarded.
  - Does not abort an in-flight sort.
  - Takes priority over an o_drop_cnt increment in the same cycle; the count becomes 0.
- A previously published o_order stays valid across invalid results and timeouts; only i_clear or reset invalidates it.

## Timing
- Reset values:
  - All outputs 0: o_order=64'h0, o_order_valid=0, o_sort_start=0, o_update=0, o_busy=0, o_timeout=0, o_drop_cnt=0, o_sort_blocks=0.
  - FSM returns to S_IDLE; last_r=0, match_cnt=0.
- Reset asserted mid-sort returns the FSM to S_IDLE immediately; no o_sort_start is issued after release until a new i_frame_done.
- Accepted i_frame_done at cycle T: o_sort_blocks updated and o_sort_start=1 at T+1; o_busy high from T+1.
- i_sort_done at cycle D: S_CHECK at D+1; o_order/o_update visible at D+2; S_IDLE and o_busy=0 at D+2.
- i_frame_done at D+2 is accepted.
- Frame-to-frame minimum spacing: sorter latency + 4 cycles.
- Timeout: return to S_IDLE exactly TIMEOUT cycles after S_START; o_timeout asserts in the same cycle the FSM enters S_IDLE.

## Configuration
- RGB_SORT_SCHED_PERM_CHECK_EN defined: an order is valid only if the 16 labels form a permutation of 0..15, i.e. each value appears exactly once. This is a one-hot OR check evaluated in S_CHECK. Duplicate labels, which can occur when the colour LUT maps to 0, reset the match state.
- Not defined: every order returned with i_sort_done is treated as valid.

## Test plan
- STABLE_CNT=3: three frames each returning 64'h0123456789ABCDEF -> o_update pulses once, 2 cycles after the third i_sort_done; o_order_valid=1; no pulse on a fourth identical frame.
- Orders A,A,B,B,B with B=64'hFEDCBA9876543210 -> the first publish is B after the fifth frame; A is never published.
- With PERM_CHECK_EN: order 64'h0023456789ABCDEF returned 3 times -> no publish; match_cnt=0. Without the macro, the same order publishes.
- Sorter never answers, TIMEOUT=64 -> o_timeout=1 exactly 64 cycles after o_sort_start; a late i_sort_done is ignored; the next frame is accepted normally.
- i_frame_done pulsed 5 times during one S_WAIT, plus 3 times with i_enable=0 -> o_drop_cnt=8 and o_sort_blocks unchanged; an i_clear pulse -> o_drop_cnt=0, o_order_valid=0.
- i_rst_n asserted in S_WAIT and released -> all outputs 0, the FSM is in S_IDLE, and a stale i_sort_done causes no update.
